float_int: RTL and testbench
============================

# float_int

Multi-cycle FPU converter from IEEE-754 single precision to 32-bit two's-complement signed integer. It is the inverse of the FPU's integer-to-float path. It accepts one operand through a valid/ready handshake and returns the integer plus exception flags after a fixed latency. It sits beside the int-to-float unit in the FPU and shares its field constants.

## Interface
- RND, default 0: rounding mode. 0 truncates toward zero (C cast). 1 rounds to nearest, ties to even.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; synchronous, active-high.
- in_valid  in  1  operand present.
- in_ready  out  1  high only in IDLE; acceptance is `in_valid && in_ready` at a rising edge.
- in  in  32  IEEE-754 single operand.
- out  out  32  signed integer result; holds its value until the next result.
- out_valid  out  1  one-cycle pulse when out and the flags are updated.
- invalid  out  1  NaN, infinity or out-of-range operand; out is saturated; valid with out_valid.
- inexact  out  1  discarded fraction bits were nonzero; valid with out_valid.

## Operation
- FSM: IDLE → UNPACK → SHIFT → ROUND → PACK → IDLE.
  - No waits; every state lasts exactly one cycle.
  - rst forces IDLE from any state.
- IDLE:
  - On acceptance, latch in; go to UNPACK.
  - out_valid is cleared here.
- UNPACK:
  - Split the operand into sign, exp[7:0] and man[22:0]; form sig = {1, man} (24 bits); compute e = exp − 127 as a 9-bit signed value.
  - Classify:
    - exp == 0: zero or denormal; result 0; inexact = (man != 0).
    - exp == 255: NaN or infinity; invalid.
    - e ≥ 31: overflow.
    - e < 0: magnitude below 1.
    - Otherwise: normal.
- SHIFT:
  - e ≥ 23: mag = sig << (e − 23); exact.
  - 0 ≤ e < 23: mag = sig >> (23 − e). Also capture:
    - guard = the first dropped bit;
    - sticky = OR of the remaining dropped bits.
  - e = −1: mag = 0, guard = 1, sticky = (man != 0).
  - e < −1: mag = 0, guard = 0, sticky = 1.
  - mag is a 32-bit unsigned value.
- ROUND:
  - RND = 1: increment mag when guard && (sticky || mag[0]).
  - RND = 0: no increment.
  - inexact = guard || sticky.
- PACK:
  - Apply sign by two's-complement negation.
  - Saturate:
    - Positive with mag ≥ 2^31 → 0x7FFFFFFF, invalid.
    - Negative with mag > 2^31 → 0x80000000, invalid.
    - Negative with mag == 2^31 → 0x80000000, valid result.
    - NaN → 0x7FFFFFFF, invalid.
    - ±Inf → saturate by sign, invalid.
  - When invalid is set, inexact is 0.
  - Register out and flags; assert out_valid; return to IDLE.
- −0.0 gives 0 with no flags.

## Timing
- Reset values:
  - state = IDLE;
  - out = 0, out_valid = 0, invalid = 0, inexact = 0;
  - in_ready = 1 immediately after reset.
- Latency: operand accepted at edge N; out and flags are registered and out_valid rises at edge N+4; out_valid falls at edge N+5.
- Throughput: one operand per 5 cycles. in_ready is high in the same cycle out_valid is high, so back-to-back accepts are legal.
- in_valid while busy: ignored; no queueing. The source must hold in_valid until in_ready.
- Reset mid-operation: the operation is dropped; no out_valid pulse; out returns to 0.
- out_valid ignores any downstream ready; the consumer must sample it on the pulse.

## Structure
- Shared package fpu_pkg holds:
  - BIAS = 127, EXP_W = 8, MAN_W = 23;
  - INT_MAX = 32'h7FFFFFFF, INT_MIN = 32'h80000000;
  - the FSM state encoding (3-bit).
- The int-to-float unit uses the same package.
- One natural sub-module: fp_unpack.
  - Combinational: sign, exp, sig, class flags (zero, nan, inf, denorm).
  - Reusable by other FPU blocks.
- Rounding and saturation stay inline in float_int.

## Test plan
- RND = 0:
  - 0x40490FDB (≈3.14159) → 0x00000003, inexact = 1.
  - 0xC0200000 (−2.5) → 0xFFFFFFFE, inexact = 1.
  - out_valid exactly 4 edges after accept.
- RND = 1:
  - 0x3FC00000 (1.5) → 2.
  - 0xC0200000 (−2.5) → −2 (tie to even).
  - 0x3F000000 (0.5) → 0, inexact = 1.
  - 0x3F400000 (0.75) → 1.
- Exact values:
  - 0x4B000001 (8388609) → 0x00800001, flags 0.
  - 0x4EFFFFFF → 0x7FFFFF80, flags 0.
  - 0x00000000 and 0x80000000 → 0, flags 0.
- Saturation:
  - 0x4F000000 (2^31) → 0x7FFFFFFF, invalid = 1.
  - 0xCF000000 (−2^31) → 0x80000000, invalid = 0.
  - 0x7F800000 (+Inf) → 0x7FFFFFFF, invalid = 1.
  - 0xFF800000 (−Inf) → 0x80000000, invalid = 1.
  - 0x7FC00000 (NaN) → 0x7FFFFFFF, invalid = 1.
  - 0x00400000 (denormal) → 0, inexact = 1.
- Handshake:
  - Hold in_valid high with two operands back-to-back: second accept in the same cycle as the first out_valid; in_valid while busy has no effect.
  - Assert rst in ROUND: no out_valid pulse; out = 0; in_ready = 1 the next cycle.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared FPU definitions: IEEE-754 single field widths, integer limits,
// converter FSM encoding and the operand classification used by the
// float<->int conversion units.
package fpu_pkg;

    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int BIAS  = 127;

    localparam logic [31:0] INT_MAX = 32'h7FFF_FFFF;
    localparam logic [31:0] INT_MIN = 32'h8000_0000;

    // Converter sequencing; every state lasts exactly one cycle.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_UNPACK = 3'd1,
        ST_SHIFT  = 3'd2,
        ST_ROUND  = 3'd3,
        ST_PACK   = 3'd4
    } fsm_state_e;

    // Operand class decided once in UNPACK and carried down the pipeline.
    typedef enum logic [2:0] {
        CLS_ZERO = 3'd0,   // zero or denormal: integer part is 0
        CLS_NAN  = 3'd1,
        CLS_INF  = 3'd2,
        CLS_OVF  = 3'd3,   // unbiased exponent >= 31
        CLS_TINY = 3'd4,   // unbiased exponent < 0, magnitude below 1
        CLS_NORM = 3'd5    // unbiased exponent 0..30
    } op_class_e;

    // Raw single-precision layout.
    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] man;
    } fp32_t;

endpackage

// File: rtl/float_int_if.sv
// Operand/result bundle of the float-to-int converter. The source drives
// the operand handshake; the converter drives the result and its flags.
interface float_int_if;

    logic        in_valid;
    logic        in_ready;
    logic [31:0] in;
    logic [31:0] out;
    logic        out_valid;
    logic        invalid;
    logic        inexact;

    modport master (
        output in_valid, in,
        input  in_ready, out, out_valid, invalid, inexact
    );

    modport slave (
        input  in_valid, in,
        output in_ready, out, out_valid, invalid, inexact
    );

endinterface

// File: rtl/fp_unpack.sv
// Combinational split of an IEEE-754 single into sign, exponent and
// significand with the hidden bit, plus the special-value class flags.
module fp_unpack
    import fpu_pkg::*;
(
    input  logic [31:0]      op_i,
    output logic             sign_o,
    output logic [EXP_W-1:0] exp_o,
    output logic [MAN_W:0]   sig_o,
    output logic             is_zero_o,
    output logic             is_denorm_o,
    output logic             is_nan_o,
    output logic             is_inf_o
);

    fp32_t f;
    logic  exp_zero;
    logic  exp_ones;
    logic  man_zero;

    assign f        = op_i;
    assign exp_zero = (f.exp == '0);
    assign exp_ones = (f.exp == '1);
    assign man_zero = (f.man == '0);

    assign sign_o      = f.sign;
    assign exp_o       = f.exp;
    assign sig_o       = {1'b1, f.man};
    assign is_zero_o   = exp_zero &&  man_zero;
    assign is_denorm_o = exp_zero && !man_zero;
    assign is_nan_o    = exp_ones && !man_zero;
    assign is_inf_o    = exp_ones &&  man_zero;

endmodule

// File: rtl/float_int.sv
// IEEE-754 single to 32-bit signed integer converter. One operand per
// five cycles: UNPACK classifies, SHIFT aligns the significand and keeps
// guard/sticky, ROUND applies the rounding mode, PACK negates/saturates.
module float_int
    import fpu_pkg::*;
#(
    parameter bit RND = 1'b0   // 0: truncate toward zero, 1: nearest, ties to even
) (
    input  logic       clk,
    input  logic       rst,
    float_int_if.slave bus
);

    // Control
    fsm_state_e state_q, state_d;
    logic       out_valid_q, out_valid_d;
    logic       accept;

    // Pipeline datapath
    logic [31:0]        op_q, op_d;
    logic               sign_q, sign_d;
    logic signed [8:0]  e_q, e_d;
    logic [MAN_W:0]     sig_q, sig_d;
    op_class_e          cls_q, cls_d;
    logic [31:0]        mag_q, mag_d;
    logic               guard_q, guard_d;
    logic               sticky_q, sticky_d;
    logic               frac_q, frac_d;

    // Result registers
    logic [31:0]        res_q, res_d;
    logic               invalid_q, invalid_d;
    logic               inexact_q, inexact_d;

    // Unpacker outputs
    logic               u_sign;
    logic [EXP_W-1:0]   u_exp;
    logic [MAN_W:0]     u_sig;
    logic               u_zero, u_denorm, u_nan, u_inf;
    logic signed [8:0]  e_unb;

    // Datapath temporaries
    logic [4:0]         lsh;
    logic [4:0]         rsh;
    logic [47:0]        ext;
    logic               round_up;

    fp_unpack u_unpack (
        .op_i        (op_q),
        .sign_o      (u_sign),
        .exp_o       (u_exp),
        .sig_o       (u_sig),
        .is_zero_o   (u_zero),
        .is_denorm_o (u_denorm),
        .is_nan_o    (u_nan),
        .is_inf_o    (u_inf)
    );

    assign e_unb = $signed({1'b0, u_exp}) - $signed(9'(BIAS));

    // Shift amounts are only used inside their exponent windows (23..30 and 0..22).
    assign lsh = e_q[4:0] - 5'd23;
    assign rsh = 5'd23 - e_q[4:0];

    assign accept        = bus.in_valid && (state_q == ST_IDLE);
    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.out       = res_q;
    assign bus.out_valid = out_valid_q;
    assign bus.invalid   = invalid_q;
    assign bus.inexact   = inexact_q;

    // Next state: leave IDLE on acceptance, then walk the stages one per cycle.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves it unassigned and no latch is inferred.
        state_d     = state_q;
        out_valid_d = 1'b0;
        unique case (state_q)
            ST_IDLE:   if (accept) state_d = ST_UNPACK;
            ST_UNPACK: state_d = ST_SHIFT;
            ST_SHIFT:  state_d = ST_ROUND;
            ST_ROUND:  state_d = ST_PACK;
            ST_PACK: begin
                state_d     = ST_IDLE;
                out_valid_d = 1'b1;
            end
            default:   state_d = ST_IDLE;
        endcase
    end

    // Per-stage datapath: each stage updates only the registers it owns.
    always_comb begin
        op_d      = op_q;
        sign_d    = sign_q;
        e_d       = e_q;
        sig_d     = sig_q;
        cls_d     = cls_q;
        mag_d     = mag_q;
        guard_d   = guard_q;
        sticky_d  = sticky_q;
        frac_d    = frac_q;
        res_d     = res_q;
        invalid_d = invalid_q;
        inexact_d = inexact_q;
        ext       = '0;
        round_up  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (accept) op_d = bus.in;
            end

            ST_UNPACK: begin
                sign_d = u_sign;
                sig_d  = u_sig;
                e_d    = e_unb;
                if (u_zero || u_denorm)      cls_d = CLS_ZERO;
                else if (u_nan)              cls_d = CLS_NAN;
                else if (u_inf)              cls_d = CLS_INF;
                else if (e_unb >= 9'sd31)    cls_d = CLS_OVF;
                else if (e_unb <  9'sd0)     cls_d = CLS_TINY;
                else                         cls_d = CLS_NORM;
            end

            ST_SHIFT: begin
                mag_d    = '0;
                guard_d  = 1'b0;
                sticky_d = 1'b0;
                unique case (cls_q)
                    // Denormal fraction is entirely below one half.
                    CLS_ZERO: sticky_d = |sig_q[MAN_W-1:0];
                    CLS_NAN, CLS_INF: ;
                    // Exactly 2^31 fits; anything larger only needs to exceed it.
                    CLS_OVF: begin
                        if (e_q == 9'sd31) mag_d = {sig_q, 8'b0};
                        else               mag_d = '1;
                    end
                    CLS_TINY: begin
                        if (e_q == -9'sd1) begin
                            guard_d  = 1'b1;
                            sticky_d = |sig_q[MAN_W-1:0];
                        end else begin
                            sticky_d = 1'b1;
                        end
                    end
                    CLS_NORM: begin
                        if (e_q >= 9'sd23) begin
                            mag_d = {8'b0, sig_q} << lsh;
                        end else begin
                            // Low half of the extended value holds the dropped bits.
                            ext      = {sig_q, 24'b0} >> rsh;
                            mag_d    = {8'b0, ext[47:24]};
                            guard_d  = ext[23];
                            sticky_d = |ext[22:0];
                        end
                    end
                    default: ;
                endcase
            end

            ST_ROUND: begin
                round_up = RND && guard_q && (sticky_q || mag_q[0]);
                mag_d    = mag_q + {31'b0, round_up};
                frac_d   = guard_q || sticky_q;
            end

            ST_PACK: begin
                invalid_d = 1'b0;
                res_d     = sign_q ? (~mag_q + 32'd1) : mag_q;
                if (cls_q == CLS_NAN) begin
                    res_d     = INT_MAX;
                    invalid_d = 1'b1;
                end else if (cls_q == CLS_INF) begin
                    res_d     = sign_q ? INT_MIN : INT_MAX;
                    invalid_d = 1'b1;
                end else if (!sign_q && mag_q[31]) begin
                    res_d     = INT_MAX;
                    invalid_d = 1'b1;
                end else if (sign_q && (mag_q > INT_MIN)) begin
                    res_d     = INT_MIN;
                    invalid_d = 1'b1;
                end
                inexact_d = frac_q && !invalid_d;
            end

            default: ;
        endcase
    end

    // Control registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: state elements use non-blocking assignments so all registers update from pre-edge values.
        if (rst) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Datapath and result registers; a reset drops any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q      <= '0;
            sign_q    <= 1'b0;
            e_q       <= '0;
            sig_q     <= '0;
            cls_q     <= CLS_ZERO;
            mag_q     <= '0;
            guard_q   <= 1'b0;
            sticky_q  <= 1'b0;
            frac_q    <= 1'b0;
            res_q     <= '0;
            invalid_q <= 1'b0;
            inexact_q <= 1'b0;
        end else begin
            op_q      <= op_d;
            sign_q    <= sign_d;
            e_q       <= e_d;
            sig_q     <= sig_d;
            cls_q     <= cls_d;
            mag_q     <= mag_d;
            guard_q   <= guard_d;
            sticky_q  <= sticky_d;
            frac_q    <= frac_d;
            res_q     <= res_d;
            invalid_q <= invalid_d;
            inexact_q <= inexact_d;
        end
    end

endmodule

// File: tb/tb_float_int.sv
// Bench for float_int: one truncating and one round-to-nearest instance
// driven with the same operands, compared against an arithmetic model.
module tb_float_int;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    float_int_if if0 ();
    float_int_if if1 ();

    float_int #(.RND(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
    float_int #(.RND(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));

    int n_cmp = 0;
    int n_err = 0;

    typedef struct packed {
        logic [31:0] val;
        logic        inv;
        logic        inx;
    } res_t;

    localparam longint I_MAX = 64'sd2147483647;
    localparam longint I_MIN = -64'sd2147483648;

    logic [31:0] dir_ops [0:19] = '{
        32'h40490FDB, 32'hC0200000, 32'h3FC00000, 32'h3F000000, 32'h3F400000,
        32'h4B000001, 32'h4EFFFFFF, 32'h00000000, 32'h80000000, 32'h4F000000,
        32'hCF000000, 32'h7F800000, 32'hFF800000, 32'h7FC00000, 32'h00400000,
        32'hCF000001, 32'hBF000000, 32'h3F000001, 32'h3E800000, 32'h3FBFFFFF
    };

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    // Value of the float as integer part plus remainder over 2^d, rounded and clamped.
    function automatic res_t ref_model(input logic [31:0] op, input bit rnd);
        res_t   r;
        int     ex;
        int     d;
        longint sig, ip, rem, half, p, v;
        r   = '0;
        ex  = int'(op[30:23]);
        sig = longint'({1'b1, op[22:0]});
        if (ex == 255) begin
            r.inv = 1'b1;
            r.val = (op[22:0] != 0 || !op[31]) ? 32'h7FFFFFFF : 32'h80000000;
            return r;
        end
        if (ex == 0) begin
            r.inx = (op[22:0] != 0);
            return r;
        end
        d = 23 - (ex - 127);
        if (d <= 0) begin
            ip   = (d < -20) ? (longint'(1) << 44) : (sig << (-d));
            rem  = 0;
            half = 1;
        end else if (d > 40) begin
            ip   = 0;
            rem  = 1;
            half = longint'(1) << 40;
        end else begin
            p    = longint'(1) << d;
            ip   = sig / p;
            rem  = sig % p;
            half = p / 2;
        end
        if (rnd && (rem > half || (rem == half && (ip % 2) == 1))) ip = ip + 1;
        r.inx = (rem != 0);
        v = op[31] ? -ip : ip;
        if (v > I_MAX) begin
            r.val = 32'h7FFFFFFF;
            r.inv = 1'b1;
        end else if (v < I_MIN) begin
            r.val = 32'h80000000;
            r.inv = 1'b1;
        end else begin
            r.val = v[31:0];
        end
        if (r.inv) r.inx = 1'b0;
        return r;
    endfunction

    task automatic drive(input logic v, input logic [31:0] d);
        if0.in_valid = v;
        if1.in_valid = v;
        if0.in       = d;
        if1.in       = d;
    endtask

    task automatic check_result(input string tag, input logic [31:0] op);
        res_t r0, r1;
        r0 = ref_model(op, 1'b0);
        r1 = ref_model(op, 1'b1);
        check($sformatf("%s op=%h rnd0 out", tag, op), if0.out, r0.val);
        check($sformatf("%s op=%h rnd0 invalid", tag, op), 32'(if0.invalid), 32'(r0.inv));
        check($sformatf("%s op=%h rnd0 inexact", tag, op), 32'(if0.inexact), 32'(r0.inx));
        check($sformatf("%s op=%h rnd1 valid", tag, op), 32'(if1.out_valid), 32'd1);
        check($sformatf("%s op=%h rnd1 out", tag, op), if1.out, r1.val);
        check($sformatf("%s op=%h rnd1 invalid", tag, op), 32'(if1.invalid), 32'(r1.inv));
        check($sformatf("%s op=%h rnd1 inexact", tag, op), 32'(if1.inexact), 32'(r1.inx));
    endtask

    // Wait (bounded) for out_valid after an accept edge, returning edges elapsed.
    task automatic wait_result(output int lat);
        bit seen;
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
            seen = if0.out_valid;
        end
    endtask

    task automatic send_op(input string tag, input logic [31:0] op);
        int lat;
        bit rdy;
        @(negedge clk);
        drive(1'b1, op);
        rdy = if0.in_ready;
        for (int i = 0; i < 10 && !rdy; i++) begin
            @(negedge clk);
            rdy = if0.in_ready;
        end
        check($sformatf("%s op=%h ready", tag, op), 32'(rdy), 32'd1);
        @(posedge clk);
        #1;
        drive(1'b0, 32'h0);
        wait_result(lat);
        check($sformatf("%s op=%h latency", tag, op), 32'(lat), 32'd4);
        if (lat < 10) check_result(tag, op);
        @(posedge clk);
        #1;
        check($sformatf("%s op=%h pulse end", tag, op), 32'(if0.out_valid), 32'd0);
    endtask

    task automatic back_to_back(input logic [31:0] a, input logic [31:0] b);
        int lat;
        @(negedge clk);
        drive(1'b1, a);
        @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 0) drive(1'b1, b);
            check($sformatf("b2b busy ready c%0d", i), 32'(if0.in_ready), 32'd0);
            check($sformatf("b2b busy valid c%0d", i), 32'(if0.out_valid), 32'd0);
        end
        @(negedge clk);
        check("b2b first valid", 32'(if0.out_valid), 32'd1);
        check("b2b ready with valid", 32'(if0.in_ready), 32'd1);
        check_result("b2b first", a);
        @(posedge clk);
        #1;
        drive(1'b0, 32'h0);
        check("b2b second taken", 32'(if0.in_ready), 32'd0);
        wait_result(lat);
        check("b2b second latency", 32'(lat), 32'd4);
        if (lat < 10) check_result("b2b second", b);
    endtask

    task automatic reset_mid_op();
        int pulses;
        @(negedge clk);
        drive(1'b1, 32'h4B000001);
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, 32'h0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midrst out0", if0.out, 32'h0);
        check("midrst out1", if1.out, 32'h0);
        check("midrst valid", 32'(if0.out_valid), 32'd0);
        check("midrst ready", 32'(if0.in_ready), 32'd1);
        pulses = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (if0.out_valid || if1.out_valid) pulses++;
        end
        check("midrst no pulse", 32'(pulses), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] rop;
        rst = 1'b1;
        drive(1'b0, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset out", if0.out, 32'h0);
        check("reset out_valid", 32'(if0.out_valid), 32'd0);
        check("reset invalid", 32'(if0.invalid), 32'd0);
        check("reset inexact", 32'(if0.inexact), 32'd0);
        check("reset in_ready", 32'(if0.in_ready), 32'd1);

        for (int i = 0; i < 20; i++) send_op("dir", dir_ops[i]);

        back_to_back(32'h3FC00000, 32'hC0200000);

        send_op("pre-rst", 32'h40490FDB);
        reset_mid_op();

        for (int i = 0; i < 150; i++) begin
            rop = $urandom;
            if (i % 3 != 0) rop[30:23] = 8'($urandom_range(100, 160));
            if (i % 5 == 0) rop[14:0] = '0;
            send_op("rand", rop);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
